exec_stage: RTL and testbench

EXEC_STAGE -- requirements
Module: exec_stage

---
 rtl/exec_if.sv | 24 ++
 rtl/exec_stage.sv | 191 +++++++++++++++++++
 tb/tb_exec_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_if.sv
// Execute-stage handshake and writeback bundle.
// The master side issues operations; the slave side accepts them and produces writebacks.
interface exec_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd_in;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        write_enable;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic        illegal_op;

  modport master (
    output in_valid, op, rd_in, data1, data2,
    input  in_ready, write_enable, rd, rd_data, illegal_op
  );

  modport slave (
    input  in_valid, op, rd_in, data1, data2,
    output in_ready, write_enable, rd, rd_data, illegal_op
  );
endinterface

// File: rtl/exec_stage.sv
// Integer execute stage: single-cycle ALU ops, bit-serial shifts, optional bit-serial MUL.
// Define EXEC_MUL_EN to enable op 10 (MUL); otherwise op 10 is reported as illegal.
module exec_stage (
  input  logic  clk,
  input  logic  reset,
  exec_if.slave io
);
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
`ifdef EXEC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd10;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  sh_op_q, sh_op_d;
  logic [4:0]  rd_pend_q, rd_pend_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        we_q, we_d;
  logic        ill_q, ill_d;
`ifdef EXEC_MUL_EN
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplr_q, mplr_d;
  logic [31:0] prod_next;
`endif

  logic        in_ready;
  logic        accept;
  logic [31:0] alu_res;
  logic [31:0] shifted;

  assign in_ready        = (state_q == IDLE) && !reset;
  assign accept          = io.in_valid && in_ready;
  assign io.in_ready     = in_ready;
  assign io.write_enable = we_q;
  assign io.illegal_op   = ill_q;
  assign io.rd           = rd_q;
  assign io.rd_data      = rd_data_q;

  always_comb begin
    alu_res = 32'd0;
    case (io.op)
      OP_ADD:  alu_res = io.data1 + io.data2;
      OP_SUB:  alu_res = io.data1 - io.data2;
      OP_AND:  alu_res = io.data1 & io.data2;
      OP_OR:   alu_res = io.data1 | io.data2;
      OP_XOR:  alu_res = io.data1 ^ io.data2;
      OP_SLT:  alu_res = {31'd0, $signed(io.data1) < $signed(io.data2)};
      OP_SLTU: alu_res = {31'd0, io.data1 < io.data2};
      default: alu_res = 32'd0;
    endcase
  end

  always_comb begin
    case (sh_op_q)
      OP_SLL:  shifted = {acc_q[30:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc_q[31:1]};
      default: shifted = {acc_q[31], acc_q[31:1]};
    endcase
  end

`ifdef EXEC_MUL_EN
  assign prod_next = acc_q + (mplr_q[0] ? mcand_q : 32'd0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sh_op_d   = sh_op_q;
    rd_pend_d = rd_pend_q;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
    we_d      = 1'b0;
    ill_d     = 1'b0;
`ifdef EXEC_MUL_EN
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (io.op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: begin
              rd_d      = io.rd_in;
              rd_data_d = alu_res;
              we_d      = 1'b1;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              if (io.data2[4:0] == 5'd0) begin
                rd_d      = io.rd_in;
                rd_data_d = io.data1;
                we_d      = 1'b1;
              end else begin
                state_d   = SHIFT;
                cnt_d     = {1'b0, io.data2[4:0]};
                acc_d     = io.data1;
                sh_op_d   = io.op;
                rd_pend_d = io.rd_in;
              end
            end
`ifdef EXEC_MUL_EN
            OP_MUL: begin
              state_d   = MUL;
              cnt_d     = 6'd32;
              acc_d     = 32'd0;
              mcand_d   = io.data1;
              mplr_d    = io.data2;
              rd_pend_d = io.rd_in;
            end
`endif
            default: ill_d = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        // Last shift bypasses acc and lands directly in the writeback register.
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d   = IDLE;
          rd_d      = rd_pend_q;
          rd_data_d = shifted;
          we_d      = 1'b1;
        end else begin
          acc_d = shifted;
        end
      end
`ifdef EXEC_MUL_EN
      MUL: begin
        cnt_d   = cnt_q - 6'd1;
        mcand_d = {mcand_q[30:0], 1'b0};
        mplr_d  = {1'b0, mplr_q[31:1]};
        if (cnt_q == 6'd1) begin
          state_d   = IDLE;
          rd_d      = rd_pend_q;
          rd_data_d = prod_next;
          we_d      = 1'b1;
        end else begin
          acc_d = prod_next;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 32'd0;
      sh_op_q   <= 4'd0;
      rd_pend_q <= 5'd0;
      rd_q      <= 5'd0;
      rd_data_q <= 32'd0;
      we_q      <= 1'b0;
      ill_q     <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q   <= 32'd0;
      mplr_q    <= 32'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sh_op_q   <= sh_op_d;
      rd_pend_q <= rd_pend_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
      we_q      <= we_d;
      ill_q     <= ill_d;
`ifdef EXEC_MUL_EN
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
`endif
    end
  end
endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: driver pushes expected writebacks (value, rd, cycle),
// an independent monitor pops and compares whenever write_enable or illegal_op fires.
module tb_exec_stage;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  exec_if io ();
  exec_stage dut (.clk(clk), .reset(reset), .io(io.slave));

  typedef struct {
    bit          ill;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model(input logic [3:0] op, input logic [4:0] rd,
                                 input logic [31:0] a, input logic [31:0] b, input int e0);
    exp_t e;
    int   k;
    k      = int'(b[4:0]);
    e.ill  = 1'b0;
    e.rd   = rd;
    e.data = 32'd0;
    e.cyc  = e0;
    case (op)
      4'd0: e.data = a + b;
      4'd1: e.data = a - b;
      4'd2: e.data = a & b;
      4'd3: e.data = a | b;
      4'd4: e.data = a ^ b;
      4'd5: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: e.data = (a < b) ? 32'd1 : 32'd0;
      4'd7: begin e.data = a << k; e.cyc = e0 + k; end
      4'd8: begin e.data = a >> k; e.cyc = e0 + k; end
      4'd9: begin e.data = $signed(a) >>> k; e.cyc = e0 + k; end
`ifdef EXEC_MUL_EN
      4'd10: begin e.data = a * b; e.cyc = e0 + 32; end
`endif
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one op; while the stage is busy it drives random junk with in_valid high,
  // which must be ignored.
  task automatic issue(input logic [3:0] op, input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] b, input bit track, output int e0);
    int n;
    n = 0;
    @(negedge clk);
    while (!io.in_ready && n < 200) begin
      io.in_valid = 1'b1;
      io.op       = 4'($urandom);
      io.rd_in    = 5'($urandom);
      io.data1    = $urandom;
      io.data2    = $urandom;
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: in_ready stayed low for %0d cycles, required high", n);
    end
    io.in_valid = 1'b1;
    io.op       = op;
    io.rd_in    = rd;
    io.data1    = a;
    io.data2    = b;
    @(posedge clk);
    #1;
    e0 = cyc;
    io.in_valid = 1'b0;
    if (track) sb.push_back(model(op, rd, a, b, e0));
  endtask

  always @(negedge clk) begin
    if (io.write_enable && io.illegal_op) begin
      checks++;
      failures++;
      $display("FAIL we_ill_overlap: both high at cycle %0d, required exclusive", cyc);
    end
    if (io.write_enable || io.illegal_op) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: we=%0b ill=%0b rd=%0d data=%h at cycle %0d, required none",
                 io.write_enable, io.illegal_op, io.rd, io.rd_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.ill) begin
          if (!io.illegal_op || io.write_enable || cyc != e.cyc) begin
            failures++;
            $display("FAIL illegal_pulse: we=%0b ill=%0b cycle %0d, required ill at cycle %0d",
                     io.write_enable, io.illegal_op, cyc, e.cyc);
          end
        end else if (!io.write_enable || io.rd !== e.rd || io.rd_data !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL writeback: we=%0b rd=%0d data=%h cycle %0d, required rd=%0d data=%h cycle %0d",
                   io.write_enable, io.rd, io.rd_data, cyc, e.rd, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    int e0;
    int w;
    logic [3:0]  op;
    logic [31:0] a, b;
    reset = 1'b1;
    io.in_valid = 1'b0;
    io.op = 4'd0;
    io.rd_in = 5'd0;
    io.data1 = 32'd0;
    io.data2 = 32'd0;
    repeat (3) @(negedge clk);
    io.in_valid = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, io.in_ready}, 32'd0);
    chk("rst_we", {31'd0, io.write_enable}, 32'd0);
    chk("rst_ill", {31'd0, io.illegal_op}, 32'd0);
    chk("rst_rd", {27'd0, io.rd}, 32'd0);
    chk("rst_rd_data", io.rd_data, 32'd0);
    io.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", {31'd0, io.in_ready}, 32'd1);

    // wrap-around ADD then SUB, back to back
    issue(4'd0, 5'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, e0);
    issue(4'd1, 5'd5, 32'd0, 32'd1, 1'b1, e0);
    // SRA by 4: stage busy exactly 4 cycles
    issue(4'd9, 5'd3, 32'h8000_0000, 32'd4, 1'b1, e0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sra_busy", {31'd0, io.in_ready}, 32'd0);
    end
    @(negedge clk);
    chk("sra_ready_again", {31'd0, io.in_ready}, 32'd1);
    issue(4'd5, 5'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, e0);
    issue(4'd6, 5'd2, 32'hFFFF_FFFF, 32'd0, 1'b1, e0);
    issue(4'd7, 5'd4, 32'h1234_5678, 32'd32, 1'b1, e0);
    issue(4'd12, 5'd6, 32'd9, 32'd9, 1'b1, e0);
    issue(4'd10, 5'd7, 32'd7, 32'd6, 1'b1, e0);
    issue(4'd0, 5'd0, 32'd10, 32'd20, 1'b1, e0);
    issue(4'd8, 5'd9, 32'hF000_000F, 32'd31, 1'b1, e0);

    // reset in the middle of a 10-step SRL: that op must never write back
    issue(4'd8, 5'd11, 32'hDEAD_BEEF, 32'd10, 1'b0, e0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, io.in_ready}, 32'd0);
    chk("midrst_rd_data", io.rd_data, 32'd0);
    chk("midrst_rd", {27'd0, io.rd}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_ready_after", {31'd0, io.in_ready}, 32'd1);
    repeat (15) @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) b[4:0] = 5'd0;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000 | a;
      issue(op, 5'($urandom), a, b, 1'b1, e0);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
